// File: rtl/prog_mem.sv
// Program memory for a nibble CPU: 16 words of {data, opcode}. The CPU reads and stores through
// addr, and a serial loader streams a new image in while the old image streams out.
module prog_mem #(
  parameter int DEPTH = 16,
  parameter int WORD  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      addr,
  input  logic            we,
  input  logic [WORD-1:0] wdata,
  output logic [WORD-1:0] rdata,
  input  logic            load_en,
  input  logic            load_di,
  output logic            load_do,
  output logic            load_done
);

  localparam int BW = $clog2(WORD);
  localparam int HI = WORD / 2;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;

  state_e                      state_q, state_d;
  logic [DEPTH-1:0][WORD-1:0]  mem_q, mem_d;
  logic [3:0]                  ptr_q, ptr_d;
  logic [BW-1:0]               bcnt_q, bcnt_d;
  logic [WORD-1:0]             sh_q, sh_d;
  logic                        load_done_q, load_done_d;
  logic [WORD-1:0]             word_in;

  // Only the data nibble of a CPU store reaches memory.
  logic unused_wdata;
  assign unused_wdata = ^wdata[HI-1:0];

  assign word_in = {sh_q[WORD-2:0], load_di};

  always_comb begin
    state_d = state_q;
    mem_d   = mem_q;
    ptr_d   = ptr_q;
    bcnt_d  = bcnt_q;
    sh_d    = sh_q;
    case (state_q)
      IDLE, DONE: begin
        if (we) mem_d[addr][WORD-1:HI] = wdata[WORD-1:HI];
        if (state_q == IDLE && load_en) begin
          state_d = LOAD;
          ptr_d   = '0;
          bcnt_d  = '0;
          sh_d    = mem_q[0];
        end
        if (state_q == DONE && !load_en) state_d = IDLE;
      end
      LOAD: begin
        if (!load_en) begin
          // Abort: the partially shifted word is dropped, completed words stay.
          state_d = IDLE;
          ptr_d   = '0;
          bcnt_d  = '0;
          sh_d    = '0;
        end else begin
          sh_d   = word_in;
          bcnt_d = bcnt_q + 1'b1;
          if (bcnt_q == BW'(WORD-1)) begin
            mem_d[ptr_q] = word_in;
            if (ptr_q == 4'(DEPTH-1)) begin
              state_d = DONE;
            end else begin
              ptr_d = ptr_q + 4'd1;
              sh_d  = mem_q[ptr_q + 4'd1];
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    load_done_d = (state_d == DONE);
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_q       <= '0;
      ptr_q       <= '0;
      bcnt_q      <= '0;
      sh_q        <= '0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      ptr_q       <= ptr_d;
      bcnt_q      <= bcnt_d;
      sh_q        <= sh_d;
      load_done_q <= load_done_d;
    end
  end

  // The CPU sees NOPs while an image is being streamed in.
  assign rdata     = (state_q == LOAD) ? '0 : mem_q[addr];
  assign load_do   = sh_q[WORD-1];
  assign load_done = load_done_q;

endmodule

// File: tb/tb_prog_mem.sv
// Directed bench for prog_mem: reset, serial loads with readback, CPU stores, abort, async reset.
module tb_prog_mem;
  logic       clk, rst_n, we, load_en, load_di, load_do, load_done;
  logic [3:0] addr;
  logic [7:0] wdata, rdata;

  int errors = 0;
  int checks = 0;

  typedef logic [7:0] img_t [16];
  img_t img_a, ones, img_b, img_c, model;

  typedef struct {
    logic [3:0] addr;
    logic       we;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs [10];

  prog_mem dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .we(we), .wdata(wdata), .rdata(rdata),
    .load_en(load_en), .load_di(load_di), .load_do(load_do), .load_done(load_done)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sweep(input string name);
    for (int a = 0; a < 16; a++) begin
      addr = 4'(a);
      #1 chk($sformatf("%s addr%0d", name, a), rdata, model[a]);
    end
  endtask

  // Enters LOAD, then shifts nbits of img MSB first, checking readback per completed word.
  task automatic load_bits(input img_t img, input int nbits, input logic we_during);
    logic [7:0] rb;
    rb = '0;
    @(posedge clk); #1 load_en = 1'b1;
    @(negedge clk);
    #1;
    if (we_during) begin
      we = 1'b1; addr = 4'd2; wdata = 8'hFF;
    end
    for (int k = 0; k < nbits; k++) begin
      @(posedge clk); #1;
      load_di = img[k/8][7-(k%8)];
      rb = {rb[6:0], load_do};
      if (k % 8 == 3) chk($sformatf("nop_in_load k%0d", k), rdata, 8'h00);
      @(negedge clk);
      if (k % 8 == 7) begin
        chk($sformatf("readback w%0d", k/8), rb, model[k/8]);
        model[k/8] = img[k/8];
      end
    end
  endtask

  task automatic drop_load();
    @(posedge clk); #1 load_en = 1'b0; we = 1'b0;
    @(negedge clk); #1;
  endtask

  initial begin
    logic [3:0] n;
    rst_n = 1'b1; we = 1'b0; load_en = 1'b0; load_di = 1'b0; addr = '0; wdata = '0;
    for (int i = 0; i < 16; i++) begin
      n        = 4'(i);
      img_a[i] = {~n, n};
      ones[i]  = 8'hFF;
      img_b[i] = 8'h00;
      img_c[i] = 8'h00;
      model[i] = 8'h00;
    end
    img_b[0] = 8'h12; img_b[1] = 8'h34; img_b[2] = 8'h56;
    img_c[0] = 8'h77;

    vecs[0] = '{4'd5,  1'b0, 8'h00, 8'hA5};
    vecs[1] = '{4'd0,  1'b0, 8'h00, 8'hF0};
    vecs[2] = '{4'd15, 1'b0, 8'h00, 8'h0F};
    vecs[3] = '{4'd3,  1'b1, 8'h90, 8'h93};
    vecs[4] = '{4'd3,  1'b0, 8'h00, 8'h93};
    vecs[5] = '{4'd7,  1'b1, 8'h3C, 8'h37};
    vecs[6] = '{4'd15, 1'b1, 8'hF0, 8'hFF};
    vecs[7] = '{4'd0,  1'b1, 8'h5A, 8'h50};
    vecs[8] = '{4'd4,  1'b0, 8'h00, 8'hB4};
    vecs[9] = '{4'd7,  1'b0, 8'h00, 8'h37};

    // Reset then read
    #2 rst_n = 1'b0;
    #1 chk("reset load_done", load_done, 8'h00);
    chk("reset load_do", load_do, 8'h00);
    @(posedge clk); #1 rst_n = 1'b1;
    sweep("reset");
    chk("reset load_done after release", load_done, 8'h00);

    // Full load of the {~i, i} image
    load_bits(img_a, 128, 1'b0);
    @(posedge clk); #1 chk("load_done after 128 bits", load_done, 8'h01);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 addr = 4'd5;
    #1 chk("done held with load_en high", load_done, 8'h01);
    chk("no restart in DONE", rdata, 8'hA5);
    drop_load();
    chk("load_done clears in IDLE", load_done, 8'h00);
    addr = 4'd5;
    #1 chk("read addr5 after load", rdata, 8'hA5);
    sweep("image_a");

    // All-ones reload streams the first image back out, then restore it
    load_bits(ones, 128, 1'b0);
    drop_load();
    load_bits(img_a, 128, 1'b0);
    drop_load();

    // CPU read/store vectors
    for (int v = 0; v < 10; v++) begin
      @(posedge clk); #1;
      addr = vecs[v].addr; we = vecs[v].we; wdata = vecs[v].wdata;
      @(negedge clk); #1 we = 1'b0;
      #1 chk($sformatf("vec%0d addr%0d", v, vecs[v].addr), rdata, vecs[v].exp);
      if (vecs[v].we) model[vecs[v].addr] = vecs[v].exp;
    end

    // Abort after 20 bits with a store attempted during the load
    load_bits(img_b, 20, 1'b1);
    drop_load();
    addr = 4'd0; #1 chk("abort word0 new", rdata, 8'h12);
    addr = 4'd1; #1 chk("abort word1 new", rdata, 8'h34);
    addr = 4'd2; #1 chk("abort word2 kept", rdata, 8'hD2);
    addr = 4'd3; #1 chk("abort word3 kept", rdata, 8'h93);
    chk("abort load_done", load_done, 8'h00);

    // A fresh load after abort starts again at word 0 bit 0
    load_bits(img_c, 8, 1'b0);
    drop_load();
    addr = 4'd0; #1 chk("reload word0", rdata, 8'h77);
    addr = 4'd1; #1 chk("reload word1 kept", rdata, 8'h34);

    // Async reset between clock edges at bit 70
    load_bits(img_a, 70, 1'b0);
    #2 rst_n = 1'b0;
    addr = 4'd5;
    #1 chk("async reset load_do", load_do, 8'h00);
    chk("async reset load_done", load_done, 8'h00);
    chk("async reset rdata", rdata, 8'h00);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 load_en = 1'b0; rst_n = 1'b1;
    @(negedge clk); #1;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    sweep("post_reset");
    chk("post reset load_done", load_done, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/prog_mem.md
PROG_MEM -- requirements
Module: prog_mem

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Parameter DEPTH, default 16: number of 8-bit words, fixed by the 4-bit address.
REQ-003 Parameter WORD, default 8: word width in bits, {data nibble[7:4], opcode nibble[3:0]}.
REQ-004 clk  input  1  system clock; all storage updates on its falling edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 addr  input  4  CPU address: PC while clk low, operand address while clk high.
REQ-007 we  input  1  CPU store strobe, valid during the clk-high phase.
REQ-008 wdata  input  8  CPU store data; only [7:4] is meaningful.
REQ-009 rdata  output  8  read word feeding the CPU data_in.
REQ-010 load_en  input  1  serial program-load request, level-sensitive.
REQ-011 load_di  input  1  serial load data, MSB of each word first.
REQ-012 load_do  output  1  serial readback of the word being overwritten, MSB first.
REQ-013 load_done  output  1  high once all 16 words have been loaded.

Function
REQ-014 rdata SHALL be combinational mem[addr] when the FSM is IDLE or DONE, and 8'h00 (NOP) while LOAD.
REQ-015 A CPU store SHALL occur at the falling edge of clk when we=1 and the FSM is IDLE or DONE.
- Effect: mem[addr][7:4] <= wdata[7:4].
- mem[addr][3:0] is unchanged.
REQ-016 The FSM SHALL have exactly three states: IDLE, LOAD, DONE.
REQ-017 Transitions, evaluated at each falling edge:
- IDLE->LOAD when load_en=1.
- LOAD->DONE after the 8th bit of word 15 is written.
- DONE->IDLE when load_en=0.
- LOAD->IDLE when load_en=0 (abort).
REQ-018 On entry to LOAD: word pointer ptr=0, bit counter bcnt=0, shift register sh loaded with mem[0].
REQ-019 In LOAD, each falling edge SHALL:
- shift sh left, inserting load_di at bit 0;
- increment bcnt (3-bit, wraps 7->0).
REQ-020 load_do SHALL equal sh[7], so the old word streams out MSB first while the new word streams in.
REQ-021 On the edge where bcnt==7:
- mem[ptr] <= {sh[6:0], load_di};
- ptr increments (4-bit);
- sh reloads from mem[ptr+1].
REQ-022 Bit timing: the first load_di bit SHALL be sampled at the first falling edge in LOAD, i.e. the edge after the IDLE->LOAD edge.
- A full load takes 128 falling edges in LOAD.
REQ-023 load_done SHALL be 1 exactly in DONE; it is registered.
REQ-024 ptr wrap SHALL NOT occur: word 15 complete forces DONE, and ptr holds 15.
REQ-025 Abort mid-word: the partial word SHALL be discarded, words already completed SHALL be retained, and ptr/bcnt SHALL clear to 0.
REQ-026 we=1 during LOAD SHALL be ignored; no memory or FSM side effect.
REQ-027 load_en held high in DONE SHALL NOT restart a load; a new load requires load_en low for at least one falling edge.
REQ-028 Accesses to the same address by a store and a following read SHALL return the stored data on the next clk-low phase (write-before-read across edges).

Reset
REQ-029 rst_n=0 SHALL immediately, without waiting for a clock edge, set:
- all 16 words to 8'h00;
- FSM to IDLE;
- ptr, bcnt and sh to 0;
- load_done=0 and load_do=0.
REQ-030 Reset asserted mid-load SHALL discard the load entirely.
- After release: IDLE, memory all zero.
- A new load requires load_en sampled high after release.
REQ-031 rst_n release SHALL be synchronised by the integrator; the block takes no action on the deasserting edge itself.

Verification
REQ-032 Reset then read: rst_n pulse, sweep addr 0..15 -> rdata=8'h00 for every address, load_done=0.
REQ-033 Full load of a 16-byte image (word i = {~i, i}), MSB first, 128 bits:
- load_done=1 after the 128th bit;
- with load_en=0, addr=5 -> rdata=8'hA5.
REQ-034 Readback: reload the REQ-033 image with all-ones data -> load_do streams the first image's bytes, MSB first (0xF0, 0xE1, ...).
REQ-035 CPU store: after the REQ-033 load, addr=3, we=1, wdata=8'h90, one falling edge -> mem[3]=8'h93.
REQ-036 Abort: drop load_en after 20 bits (word 2, bit 4):
- words 0-1 hold the new values;
- word 2 holds its prior value;
- FSM is IDLE;
- we=1 during the load did not change memory.
REQ-037 Async reset mid-load: rst_n=0 at bit 70, between clock edges -> outputs clear immediately, all words 8'h00 after release, load_done=0.
